// File: rtl/datamem_arbiter.sv
// datamem_arbiter: two-requester arbiter/sequencer in front of the
// single-port data memory. It accepts one request at a time and drives the
// memory for exactly one cycle. It then returns a one-cycle response pulse
// to the requester that was granted.
//
// Build option: define DATAMEM_ARB_RR_EN for round-robin arbitration.
// Without it, port 0 has fixed priority over port 1.
module datamem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1     // memory read latency, 1..7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_enable,
  output logic              mem_readwrite,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // The counter preload is the number of WAIT cycles left after the first one.
  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t            state, state_nxt;
  logic [2:0]        cnt_q, cnt_nxt;
  logic              own_q;         // 0: port 0 owns the access, 1: port 1
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              grant0, grant1;
  logic              accept;
  logic              capture;

`ifdef DATAMEM_ARB_RR_EN
  // last_q=1 means port 1 was granted last, so port 0 wins the first contention.
  logic last_q;

  // Round-robin history: remember which port was granted on each accept.
  always_ff @(posedge clk) begin
    if (rst)         last_q <= 1'b1;
    else if (accept) last_q <= req1_ready;
  end

  assign grant0 = req0_valid & (~req1_valid |  last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);
`else
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & ~req0_valid;
`endif

  // Reset overrides the handshake, so nothing is accepted while rst is high.
  assign req0_ready = (state == IDLE) & ~rst & grant0;
  assign req1_ready = (state == IDLE) & ~rst & grant1;
  assign accept     = req0_ready | req1_ready;

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rsp0_rdata = rdata0_q;
  assign rsp1_rdata = rdata1_q;

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Sequencer: next state, memory strobes and response pulses.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt_q;
    mem_enable    = 1'b0;
    mem_readwrite = 1'b0;
    rsp0_valid    = 1'b0;
    rsp1_valid    = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_enable    = 1'b1;
        mem_readwrite = we_q;
        if (we_q) begin
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = LAT_M1;
        end
      end
      WAIT: begin
        // The final WAIT cycle is the one in which mem_rdata is valid.
        if (cnt_q == 3'd0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt_q - 3'd1;
        end
      end
      RESP: begin
        rsp0_valid = ~own_q;
        rsp1_valid =  own_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, read-data capture and write-ack clear per port.
  always_ff @(posedge clk) begin
    if (rst) begin
      own_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (accept) begin
        own_q   <= req1_ready;
        we_q    <= req1_ready ? req1_we    : req0_we;
        addr_q  <= req1_ready ? req1_addr  : req0_addr;
        wdata_q <= req1_ready ? req1_wdata : req0_wdata;
      end
      // A write ack returns 0 on the owner's response data.
      if (state == ISSUE && we_q) begin
        if (own_q) rdata1_q <= '0;
        else       rdata0_q <= '0;
      end
      if (capture) begin
        if (own_q) rdata1_q <= mem_rdata;
        else       rdata0_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter. Four instances run side by side with
// RD_LAT = 1..4. Each instance has its own behavioural memory. Shared
// request inputs are driven after the rising edge, and outputs are sampled
// on the falling edge.
module tb_datamem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;

  logic rdy0 [4], rdy1 [4], rv0 [4], rv1 [4], men [4], mrw [4];
  logic [31:0] rd0 [4], rd1 [4], maddr [4], mwd [4], mrd [4];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    logic [31:0] mem [16];
    logic [31:0] pd [4];
    logic        pv [4];

    datamem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(g + 1)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(rdy0[g]), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rv0[g]), .rsp0_rdata(rd0[g]),
      .req1_valid(req1_valid), .req1_ready(rdy1[g]), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rv1[g]), .rsp1_rdata(rd1[g]),
      .mem_addr(maddr[g]), .mem_wdata(mwd[g]), .mem_enable(men[g]),
      .mem_readwrite(mrw[g]), .mem_rdata(mrd[g])
    );

    // Memory model: data appears g+1 cycles after the enable cycle, and
    // reads as DEADBEEF on every other cycle.
    always @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < 16; k++) mem[k] <= '0;
        for (int k = 0; k < 4; k++) pv[k] <= 1'b0;
      end else begin
        if (men[g] && mrw[g]) mem[maddr[g][3:0]] <= mwd[g];
        pd[0] <= mem[maddr[g][3:0]];
        pv[0] <= men[g] & ~mrw[g];
        for (int k = 1; k < 4; k++) begin
          pd[k] <= pd[k-1];
          pv[k] <= pv[k-1];
        end
      end
    end
    assign mrd[g] = pv[g] ? pd[g] : 32'hDEADBEEF;
  end

  // Observation record, filled by observe() for all four instances.
  int ob_en_n [4], ob_en_k [4], ob_r0_k [4], ob_r0_n [4], ob_r1_k [4], ob_r1_n [4];
  logic ob_rw [4];
  logic [31:0] ob_addr [4], ob_wd [4], ob_r0_d [4], ob_r1_d [4];
  bit ob_coinc [4];

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    next(); next();
    rst = 1'b0;
  endtask

  // Present one request and hold it until instance 0 accepts it. The task
  // returns in the cycle after the accept, with valid dropped.
  task automatic send(input bit p, input bit we, input logic [31:0] a,
                      input logic [31:0] d, output bit ok);
    ok = 1'b0;
    if (p) begin req1_we = we; req1_addr = a; req1_wdata = d; req1_valid = 1'b1; end
    else   begin req0_we = we; req0_addr = a; req0_wdata = d; req0_valid = 1'b1; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (p ? rdy1[0] : rdy0[0]) ok = 1'b1;
      next();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // Record n cycles of activity. Cycle k=1 is the cycle after the accept.
  task automatic observe(input int n);
    for (int g = 0; g < 4; g++) begin
      ob_en_n[g] = 0; ob_en_k[g] = -1; ob_r0_k[g] = -1; ob_r0_n[g] = 0;
      ob_r1_k[g] = -1; ob_r1_n[g] = 0; ob_coinc[g] = 1'b0;
      ob_rw[g] = 1'bx; ob_addr[g] = 'x; ob_wd[g] = 'x; ob_r0_d[g] = 'x; ob_r1_d[g] = 'x;
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (men[g] === 1'b1) begin
          ob_en_n[g]++;
          if (ob_en_k[g] < 0) begin
            ob_en_k[g] = k; ob_rw[g] = mrw[g]; ob_addr[g] = maddr[g]; ob_wd[g] = mwd[g];
          end
        end
        if (rv0[g] === 1'b1) begin
          ob_r0_n[g]++;
          if (ob_r0_k[g] < 0) begin ob_r0_k[g] = k; ob_r0_d[g] = rd0[g]; end
        end
        if (rv1[g] === 1'b1) begin
          ob_r1_n[g]++;
          if (ob_r1_k[g] < 0) begin ob_r1_k[g] = k; ob_r1_d[g] = rd1[g]; end
        end
        if (rv0[g] === 1'b1 && rv1[g] === 1'b1) ob_coinc[g] = 1'b1;
      end
      next();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'd1; req0_wdata = '0;
    next();
    @(negedge clk);
    n_cmp++;
    if (rdy0[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_gated got %b want 0", rdy0[0]);
    end
    next();
    rst = 1'b0; req0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rdy0[0], rdy1[0], rv0[0], rv1[0], rd0[0], rd1[0], maddr[0], mwd[0], men[0], mrw[0]} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rsp0=%h rsp1=%h addr=%h wdata=%h en=%b rw=%b want all 0",
               rd0[0], rd1[0], maddr[0], mwd[0], men[0], mrw[0]);
    end
    next();
  endtask

  task automatic test_read();
    bit ok;
    send(0, 0, 32'd1, 32'd0, ok);
    observe(6);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL read_accept got %b want 1", ok); end
    n_cmp++;
    if (ob_en_k[0] !== 1 || ob_en_n[0] !== 1 || ob_rw[0] !== 1'b0 || ob_addr[0] !== 32'd1) begin
      n_fail++;
      $display("FAIL read_issue got k=%0d n=%0d rw=%b addr=%h want k=1 n=1 rw=0 addr=1",
               ob_en_k[0], ob_en_n[0], ob_rw[0], ob_addr[0]);
    end
    n_cmp++;
    if (ob_r0_k[0] !== 3 || ob_r0_n[0] !== 1 || ob_r0_d[0] !== 32'h0 || ob_r1_n[0] !== 0) begin
      n_fail++;
      $display("FAIL read_resp got k=%0d n=%0d data=%h rsp1=%0d want k=3 n=1 data=0 rsp1=0",
               ob_r0_k[0], ob_r0_n[0], ob_r0_d[0], ob_r1_n[0]);
    end
  endtask

  task automatic test_store_load();
    bit ok;
    send(0, 1, 32'd1, 32'hFFFFFFFF, ok);
    observe(4);
    n_cmp++;
    if (ob_en_k[0] !== 1 || ob_rw[0] !== 1'b1 || ob_wd[0] !== 32'hFFFFFFFF || ob_addr[0] !== 32'd1) begin
      n_fail++;
      $display("FAIL store_issue got k=%0d rw=%b wdata=%h addr=%h want k=1 rw=1 wdata=ffffffff addr=1",
               ob_en_k[0], ob_rw[0], ob_wd[0], ob_addr[0]);
    end
    n_cmp++;
    if (ob_r0_k[0] !== 2 || ob_r0_d[0] !== 32'h0) begin
      n_fail++; $display("FAIL store_ack got k=%0d data=%h want k=2 data=0", ob_r0_k[0], ob_r0_d[0]);
    end
    send(0, 0, 32'd1, 32'd0, ok);
    observe(6);
    n_cmp++;
    if (ob_r0_k[0] !== 3 || ob_r0_d[0] !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL load_after_store got k=%0d data=%h want k=3 data=ffffffff", ob_r0_k[0], ob_r0_d[0]);
    end
    n_cmp++;
    if (rd0[0] !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL rdata_hold got %h want ffffffff", rd0[0]);
    end
    // A later store must clear the held read data in its ack.
    send(0, 1, 32'd1, 32'h00001234, ok);
    observe(4);
    n_cmp++;
    if (ob_r0_k[0] !== 2 || ob_r0_d[0] !== 32'h0) begin
      n_fail++; $display("FAIL store_ack_clears got k=%0d data=%h want k=2 data=0", ob_r0_k[0], ob_r0_d[0]);
    end
    send(0, 0, 32'd1, 32'd0, ok);
    observe(6);
    n_cmp++;
    if (ob_r0_d[0] !== 32'h00001234) begin
      n_fail++; $display("FAIL reload got %h want 00001234", ob_r0_d[0]);
    end
  endtask

  task automatic test_contention();
    logic [3:0] ordv, exp_ord;
    logic [3:0][3:0] alog;
    logic [15:0] exp_alog;
    int n, na, c0, c1;
    bit viol, coinc;
    do_reset();
    ordv = '0; alog = '0; n = 0; na = 0; c0 = 2; c1 = 2; viol = 1'b0; coinc = 1'b0;
`ifdef DATAMEM_ARB_RR_EN
    exp_ord = 4'b1010; exp_alog = 16'h3232;
`else
    exp_ord = 4'b1100; exp_alog = 16'h3322;
`endif
    req0_we = 1'b0; req0_addr = 32'd2; req1_we = 1'b0; req1_addr = 32'd3;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rdy0[0] && rdy1[0]) viol = 1'b1;
`ifndef DATAMEM_ARB_RR_EN
      if (rdy1[0] && req0_valid) viol = 1'b1;
`endif
      if (rdy0[0]) begin if (n < 4) ordv[n] = 1'b0; n++; c0--; end
      if (rdy1[0]) begin if (n < 4) ordv[n] = 1'b1; n++; c1--; end
      if (rv0[0] && rv1[0]) coinc = 1'b1;
      if (men[0]) begin if (na < 4) alog[na] = maddr[0][3:0]; na++; end
      next();
      if (c0 <= 0) req0_valid = 1'b0;
      if (c1 <= 0) req1_valid = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++;
    if (n !== 4 || ordv !== exp_ord) begin
      n_fail++; $display("FAIL grant_order got n=%0d order=%b want n=4 order=%b", n, ordv, exp_ord);
    end
    n_cmp++;
    if (na !== 4 || alog !== exp_alog) begin
      n_fail++; $display("FAIL addr_sequence got n=%0d seq=%h want n=4 seq=%h", na, alog, exp_alog);
    end
    n_cmp++;
    if (viol !== 1'b0 || coinc !== 1'b0) begin
      n_fail++; $display("FAIL contention_rules got ready_viol=%b rsp_overlap=%b want 0 0", viol, coinc);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    do_reset();
    send(0, 0, 32'd4, 32'd0, ok);   // now in T+1
    next();                          // T+2, WAIT for RD_LAT=3
    next();                          // T+3, WAIT
    rst = 1'b1;
    next();                          // T+4, first cycle after reset
    rst = 1'b0;
    req1_we = 1'b0; req1_addr = 32'd3; req1_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rdy1[2] !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_accept got %b want 1", rdy1[2]);
    end
    next();
    req1_valid = 1'b0;
    observe(8);
    n_cmp++;
    if (ob_r0_n[2] !== 0) begin
      n_fail++; $display("FAIL dropped_resp got %0d rsp0 pulses want 0", ob_r0_n[2]);
    end
    n_cmp++;
    if (ob_en_n[2] !== 1 || ob_addr[2] !== 32'd3 || ob_r1_k[2] !== 5 || ob_r1_d[2] !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset_read got en=%0d addr=%h k=%0d data=%h want en=1 addr=3 k=5 data=0",
               ob_en_n[2], ob_addr[2], ob_r1_k[2], ob_r1_d[2]);
    end
  endtask

  task automatic test_latency_sweep();
    bit ok;
    do_reset();
    send(0, 1, 32'd5, 32'hA5A50001, ok);
    observe(4);
    send(0, 0, 32'd5, 32'd0, ok);
    observe(8);
    for (int g = 0; g < 4; g++) begin
      n_cmp++;
      if (ob_en_n[g] !== 1 || ob_r0_n[g] !== 1 || ob_r0_k[g] !== g + 3 || ob_r0_d[g] !== 32'hA5A50001) begin
        n_fail++;
        $display("FAIL latency_%0d got en=%0d n=%0d k=%0d data=%h want en=1 n=1 k=%0d data=a5a50001",
                 g + 1, ob_en_n[g], ob_r0_n[g], ob_r0_k[g], ob_r0_d[g], g + 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_store_load();
    test_contention();
    test_reset_mid_read();
    test_latency_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
